trng_pool: RTL and testbench

Multi-channel TRNG front end. Synchronises NUM_CH free-running entropy bits and XOR-combines them into one raw bit per cycle. Applies an optional von Neumann corrector, assembles OUT_W-bit words, and presents them on a valid/ready port. Includes a continuous repetition-count health test. Sits between the physical oscillator bank and the consumer, such as a DRBG seeder or CSR read port.

---
 rtl/trng_pool.sv | 169 ++++++++++++++++
 tb/tb_trng_pool.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/trng_pool.sv
// trng_pool: multi-channel TRNG front end. Synchronised channels are XOR-combined, health-tested,
// optionally von Neumann corrected (build macro TRNG_VN_EN), packed into words behind valid/ready.
module trng_pool #(
   parameter int NUM_CH    = 4,
   parameter int OUT_W     = 8,
   parameter int REP_LIMIT = 16
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              en,
   input  logic [NUM_CH-1:0] ent_in,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              health_fail
);
   // state           | meaning
   // PAIR_IDLE       | waiting for the first bit of a von Neumann pair
   // PAIR_HAVE_FIRST | first bit stored, next sample decides emit/discard

   localparam int CNT_W = $clog2(REP_LIMIT + 1);
   localparam int BC_W  = $clog2(OUT_W);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(OUT_W - 1);
   localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REP_LIMIT);

   logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic              raw_q, raw_d;
   logic              samp_q, samp_d;
   logic              last_bit_q, last_bit_d;
   logic [CNT_W-1:0]  rep_cnt_q, rep_cnt_d;
   logic              health_fail_q, health_fail_d;
   logic [OUT_W-1:0]  sr_q, sr_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic              pend_q, pend_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;
   logic              emit, emit_bit, slot_free, load;

`ifdef TRNG_VN_EN
   typedef enum logic {PAIR_IDLE, PAIR_HAVE_FIRST} pair_t;
   pair_t pair_q, pair_d;
   logic  first_q, first_d;
`endif

   always_comb begin
      sync1_d    = ent_in;
      sync2_d    = sync1_q;
      raw_d      = en ? ^sync2_q : raw_q;
      samp_d     = en;
      last_bit_d = last_bit_q;
      rep_cnt_d  = rep_cnt_q;

      // A zero count means no sample seen since reset, so the first one always restarts the run.
      if (samp_q) begin
         if ((rep_cnt_q != '0) && (raw_q == last_bit_q)) begin
            if (rep_cnt_q != REP_MAX)
               rep_cnt_d = rep_cnt_q + 1'b1;
         end else begin
            rep_cnt_d  = CNT_W'(1);
            last_bit_d = raw_q;
         end
      end
      health_fail_d = health_fail_q | (rep_cnt_d == REP_MAX);

`ifdef TRNG_VN_EN
      pair_d   = pair_q;
      first_d  = first_q;
      emit     = 1'b0;
      emit_bit = first_q;
      if (!en) begin
         pair_d = PAIR_IDLE;
      end else if (samp_q) begin
         if (pair_q == PAIR_IDLE) begin
            first_d = raw_q;
            pair_d  = PAIR_HAVE_FIRST;
         end else begin
            emit   = (raw_q != first_q);
            pair_d = PAIR_IDLE;
         end
      end
`else
      emit     = samp_q;
      emit_bit = raw_q;
`endif

      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      pend_d      = pend_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      load        = 1'b0;
      slot_free   = !out_valid_q || out_ready;

      // A completed word that could not be placed waits in sr; bits arriving meanwhile are lost.
      if (health_fail_q) begin
         out_valid_d = 1'b0;
      end else begin
         if (pend_q) begin
            if (slot_free) begin
               load      = 1'b1;
               pend_d    = 1'b0;
               bit_cnt_d = '0;
            end
         end else if (emit) begin
            sr_d = {sr_q[OUT_W-2:0], emit_bit};
            if (bit_cnt_q == LAST_BIT) begin
               if (slot_free) begin
                  load      = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  pend_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end

         if (load) begin
            out_data_d  = sr_d;
            out_valid_d = 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         raw_q         <= 1'b0;
         samp_q        <= 1'b0;
         last_bit_q    <= 1'b0;
         rep_cnt_q     <= '0;
         health_fail_q <= 1'b0;
         sr_q          <= '0;
         bit_cnt_q     <= '0;
         pend_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
`ifdef TRNG_VN_EN
         pair_q        <= PAIR_IDLE;
         first_q       <= 1'b0;
`endif
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         raw_q         <= raw_d;
         samp_q        <= samp_d;
         last_bit_q    <= last_bit_d;
         rep_cnt_q     <= rep_cnt_d;
         health_fail_q <= health_fail_d;
         sr_q          <= sr_d;
         bit_cnt_q     <= bit_cnt_d;
         pend_q        <= pend_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
`ifdef TRNG_VN_EN
         pair_q        <= pair_d;
         first_q       <= first_d;
`endif
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_pool.sv
// tb_trng_pool: scoreboard bench for trng_pool; expected words are queued as bit streams are
// issued and a monitor pops them on every handshake. Works with or without TRNG_VN_EN.
module tb_trng_pool;
   logic       clk = 1'b0;
   logic       n_reset;
   logic       en;
   logic [3:0] ent_in;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       health_fail;

   int total  = 0;
   int passed = 0;

   logic [7:0] exp_q[$];
   logic       stim[$];
   logic       vhist[$];

   trng_pool #(.NUM_CH(4), .OUT_W(8), .REP_LIMIT(16)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .en          (en),
      .ent_in      (ent_in),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .health_fail (health_fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   // Monitor: every accepted word must match the oldest expected word.
   always @(negedge clk) begin
      if (n_reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_word actual=%0h required=none", out_data);
         end else begin
            check("word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random channel pattern whose XOR parity equals b.
   task automatic drive_bit(input logic b);
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      ent_in = {r, b ^ (^r)};
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      en      = 1'b0;
      ent_in  = 4'b0000;
      tick();
      tick();
      n_reset = 1'b1;
      stim.delete();
   endtask

   task automatic push_bit(input logic b);
`ifdef TRNG_VN_EN
      stim.push_back(b);
      stim.push_back(~b);
`else
      stim.push_back(b);
`endif
   endtask

   task automatic push_word(input logic [7:0] w, input bit expect_it);
      for (int i = 7; i >= 0; i--) push_bit(w[i]);
      if (expect_it) exp_q.push_back(w);
   endtask

   // Streams stim one raw sample per cycle, plus a trailing filler sample.
   task automatic run_stream();
      int n;
      stim.push_back(1'b0);
      n = stim.size();
      vhist.delete();
      en = 1'b0;
      drive_bit(stim[0]);
      tick();
      drive_bit(stim[1]);
      tick();
      en = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (i + 2 < n) drive_bit(stim[i + 2]);
         else drive_bit(1'b0);
         tick();
         vhist.push_back(out_valid);
      end
      en = 1'b0;
      stim.delete();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int len;
      int highs;
      out_ready = 1'b1;
      do_reset();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_health_fail", health_fail, 0);

      // Single words; under VN these become 1,0 / 0,1 pair patterns.
      push_word(8'hFF, 1'b1);
      run_stream();
      drain("drain_ff");
      check("ff_health", health_fail, 0);

      do_reset();
      push_word(8'h00, 1'b1);
      run_stream();
      drain("drain_00");

      do_reset();
      push_word(8'hB2, 1'b1);
      len = stim.size();
      run_stream();
      check("b2_valid_before", vhist[len - 1], 0);
      check("b2_valid_after", vhist[len], 1);
      drain("drain_b2");

      do_reset();
      push_word(8'h5A, 1'b1);
      push_word(8'hC3, 1'b1);
      run_stream();
      drain("drain_5a_c3");

`ifdef TRNG_VN_EN
      do_reset();
      for (int i = 0; i < 16; i++) begin
         stim.push_back(1'b1); stim.push_back(1'b1);
         stim.push_back(1'b0); stim.push_back(1'b0);
      end
      run_stream();
      highs = 0;
      foreach (vhist[i]) if (vhist[i]) highs++;
      check("vn_1100_no_valid", highs, 0);
      check("vn_1100_health", health_fail, 0);
`endif

      // Backpressure: second word waits, trailing bits are dropped.
      do_reset();
      out_ready = 1'b0;
      push_word(8'h3C, 1'b1);
      push_word(8'hA5, 1'b1);
      push_word(8'hF0, 1'b0);
      run_stream();
      check("bp_valid_held", out_valid, 1);
      check("bp_data_held", out_data, 8'h3C);
      for (int i = 0; i < 4; i++) tick();
      check("bp_data_stable", out_data, 8'h3C);
      out_ready = 1'b1;
      tick();
      check("bp_second_data", out_data, 8'hA5);
      check("bp_second_valid", out_valid, 1);
      drain("drain_bp");
      tick();
      tick();
      check("bp_no_third", out_valid, 0);

      // Health: constant zero raw stream trips on the 16th identical sample.
      do_reset();
      out_ready = 1'b1;
`ifndef TRNG_VN_EN
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
`endif
      en = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 16) check("hf_before_trip", health_fail, 0);
         if (k == 17) check("hf_trip", health_fail, 1);
      end
      tick();
      check("hf_valid_forced", out_valid, 0);
      highs = 0;
      for (int k = 0; k < 20; k++) begin
         drive_bit(k[0]);
         tick();
         if (out_valid) highs++;
      end
      en = 1'b0;
      check("hf_valid_stays_low", highs, 0);
      check("hf_sticky", health_fail, 1);
      drain("drain_hf");
      do_reset();
      check("hf_cleared", health_fail, 0);

      // Reset with a full slot and a partial word pending.
      out_ready = 1'b0;
      push_word(8'h96, 1'b0);
      push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b1);
      run_stream();
      check("mid_valid_pre", out_valid, 1);
      n_reset = 1'b0;
      tick();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      tick();
      n_reset = 1'b1;
      out_ready = 1'b1;
      push_word(8'h69, 1'b1);
      run_stream();
      drain("drain_fresh");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
